// File: rtl/mor1kx_bus_if_wb_burst.sv
// Registered Wishbone B3 master for a mor1kx cache/LSU port: wrapped read bursts, bounded rty retry, optional watchdog (MOR1KX_BUS_IF_WB_TIMEOUT_EN).
// Latency: cyc/stb rise 1 cycle after cpu_req_i; cpu_ack_o/cpu_err_o in the slave response cycle; the bridge stalls until the slave answers.
module mor1kx_bus_if_wb_burst #(
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LENGTH   = 8,
    parameter int RETRY_MAX      = 3,
    parameter int RETRY_DELAY    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_i,
    input  logic [31:0]               cpu_adr_i,
    input  logic [DATA_WIDTH-1:0]     cpu_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   cpu_bsel_i,
    input  logic                      cpu_we_i,
    input  logic                      cpu_burst_i,
    output logic                      cpu_ack_o,
    output logic                      cpu_err_o,
    output logic [DATA_WIDTH-1:0]     cpu_dat_o,
    output logic [31:0]               wbm_adr_o,
    output logic [DATA_WIDTH-1:0]     wbm_dat_o,
    output logic [DATA_WIDTH/8-1:0]   wbm_sel_o,
    output logic                      wbm_we_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic [2:0]                wbm_cti_o,
    output logic [1:0]                wbm_bte_o,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,
    input  logic                      wbm_rty_i,
    input  logic [DATA_WIDTH-1:0]     wbm_dat_i
);
    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int BTW   = $clog2(BURST_LENGTH) + 1;
    localparam int RW    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int DLW   = $clog2(RETRY_DELAY + 1);
    localparam logic [31:0]    LANE_MASK = 32'(SEL_W - 1);
    localparam logic [31:0]    WRAP_MASK = 32'(BURST_LENGTH * SEL_W - 1) & ~LANE_MASK;
    localparam logic [BTW-1:0] LAST_BEAT = BTW'(BURST_LENGTH - 1);
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE = (BURST_LENGTH == 16) ? 2'b11 :
                                 (BURST_LENGTH == 8)  ? 2'b10 :
                                 (BURST_LENGTH == 4)  ? 2'b01 : 2'b00;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) ||
        !(BURST_LENGTH == 1 || BURST_LENGTH == 4 || BURST_LENGTH == 8 || BURST_LENGTH == 16) ||
        RETRY_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mor1kx_bus_if_wb_burst: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_SINGLE, S_BURST, S_BACKOFF, S_GAP} state_t;

    state_t                r_state;
    logic                  r_cyc, r_we, r_burst, r_abort;
    logic [31:0]           r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [SEL_W-1:0]      r_sel;
    logic [2:0]            r_cti;
    logic [BTW-1:0]        r_beat;
    logic [RW-1:0]         r_retry;
    logic [DLW-1:0]        r_delay;

    logic w_err_in, w_ack_in, w_rty_in, w_rty_fail, w_timeout, w_abort, w_err;

    // Response priority: err over ack over rty; anything seen while cyc is low is dropped.
    assign w_err_in   = r_cyc & wbm_err_i;
    assign w_ack_in   = r_cyc & wbm_ack_i & ~wbm_err_i;
    assign w_rty_in   = r_cyc & wbm_rty_i & ~wbm_err_i & ~wbm_ack_i;
    assign w_rty_fail = w_rty_in & (r_retry == RW'(RETRY_MAX));
    assign w_abort    = r_burst & r_cyc & (r_abort | ~cpu_req_i);
    assign w_err      = w_err_in | w_rty_fail | w_timeout;

`ifdef MOR1KX_BUS_IF_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_resp;
    assign w_resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign w_timeout = r_cyc & ~w_resp & (r_to_cnt == TW'(TIMEOUT_CYCLES));
    always_ff @(posedge clk) begin
        if (rst || !r_cyc || w_resp || w_timeout) r_to_cnt <= '0;
        else                                      r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign cpu_ack_o = w_ack_in & ~w_abort;
    assign cpu_err_o = w_err;
    assign cpu_dat_o = cpu_ack_o ? wbm_dat_i : '0;

    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = r_sel;
    assign wbm_we_o  = r_we;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_cti_o = r_cti;
    assign wbm_bte_o = BTE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_burst <= 1'b0;
            r_abort <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_cti   <= CTI_CLASSIC;
            r_beat  <= '0;
            r_retry <= '0;
            r_delay <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    r_retry <= '0;
                    r_beat  <= '0;
                    r_delay <= '0;
                    if (cpu_req_i) begin
                        r_adr <= cpu_adr_i & ~LANE_MASK;
                        r_dat <= cpu_dat_i;
                        r_sel <= cpu_bsel_i;
                        r_we  <= cpu_we_i;
                        r_cyc <= 1'b1;
                        if (BURST_LENGTH > 1 && cpu_burst_i && !cpu_we_i) begin
                            r_state <= S_BURST;
                            r_burst <= 1'b1;
                            r_cti   <= CTI_INC;
                        end else begin
                            r_state <= S_SINGLE;
                            r_burst <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                        end
                    end
                end
                S_SINGLE, S_BURST: begin
                    if (r_burst && !cpu_req_i) r_abort <= 1'b1;
                    if (w_err) begin
                        r_cyc   <= 1'b0;
                        r_cti   <= CTI_CLASSIC;
                        r_state <= S_GAP;
                    end else if (w_ack_in) begin
                        r_retry <= '0;
                        if (!r_burst || w_abort || r_beat == LAST_BEAT) begin
                            r_cyc   <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                            r_state <= S_GAP;
                        end else begin
                            // Wrap inside the line: only the beat-index bits advance.
                            r_adr  <= (r_adr & ~WRAP_MASK) | ((r_adr + 32'(SEL_W)) & WRAP_MASK);
                            r_beat <= r_beat + 1'b1;
                            r_cti  <= (r_beat + 1'b1 == LAST_BEAT) ? CTI_EOB : CTI_INC;
                        end
                    end else if (w_rty_in) begin
                        r_retry <= r_retry + 1'b1;
                        r_cyc   <= 1'b0;
                        r_delay <= '0;
                        r_state <= S_BACKOFF;
                    end
                end
                S_BACKOFF: begin
                    if (r_burst && (r_abort || !cpu_req_i)) begin
                        r_cti   <= CTI_CLASSIC;
                        r_state <= S_GAP;
                    end else if (r_delay == DLW'(RETRY_DELAY - 1)) begin
                        r_cyc   <= 1'b1;
                        r_state <= r_burst ? S_BURST : S_SINGLE;
                    end else begin
                        r_delay <= r_delay + 1'b1;
                    end
                end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mor1kx_bus_if_wb_burst.sv
// Directed bench: instance A is 32-bit / 8-beat / watchdog 16, instance B is 64-bit / 4-beat.
// Slave responses are driven at the falling edge and bridge outputs are sampled 1 time unit later.
module tb_mor1kx_bus_if_wb_burst;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int n_tests, n_fail;

    logic        a_req, a_we, a_burst, a_ack, a_err, a_wwe, a_cyc, a_stb, a_wack, a_werr, a_wrty;
    logic [31:0] a_adr, a_dat, a_cdat, a_wadr, a_wdat, a_wdati;
    logic [3:0]  a_bsel, a_wsel;
    logic [2:0]  a_cti;
    logic [1:0]  a_bte;

    logic        b_req, b_we, b_burst, b_ack, b_err, b_wwe, b_cyc, b_stb, b_wack, b_werr, b_wrty;
    logic [31:0] b_adr, b_wadr;
    logic [63:0] b_dat, b_cdat, b_wdat, b_wdati;
    logic [7:0]  b_bsel, b_wsel;
    logic [2:0]  b_cti;
    logic [1:0]  b_bte;

    mor1kx_bus_if_wb_burst #(.DATA_WIDTH(32), .BURST_LENGTH(8), .RETRY_MAX(3),
                             .RETRY_DELAY(4), .TIMEOUT_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .cpu_req_i(a_req), .cpu_adr_i(a_adr), .cpu_dat_i(a_dat),
        .cpu_bsel_i(a_bsel), .cpu_we_i(a_we), .cpu_burst_i(a_burst), .cpu_ack_o(a_ack),
        .cpu_err_o(a_err), .cpu_dat_o(a_cdat), .wbm_adr_o(a_wadr), .wbm_dat_o(a_wdat),
        .wbm_sel_o(a_wsel), .wbm_we_o(a_wwe), .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb),
        .wbm_cti_o(a_cti), .wbm_bte_o(a_bte), .wbm_ack_i(a_wack), .wbm_err_i(a_werr),
        .wbm_rty_i(a_wrty), .wbm_dat_i(a_wdati));

    mor1kx_bus_if_wb_burst #(.DATA_WIDTH(64), .BURST_LENGTH(4), .RETRY_MAX(3),
                             .RETRY_DELAY(4), .TIMEOUT_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .cpu_req_i(b_req), .cpu_adr_i(b_adr), .cpu_dat_i(b_dat),
        .cpu_bsel_i(b_bsel), .cpu_we_i(b_we), .cpu_burst_i(b_burst), .cpu_ack_o(b_ack),
        .cpu_err_o(b_err), .cpu_dat_o(b_cdat), .wbm_adr_o(b_wadr), .wbm_dat_o(b_wdat),
        .wbm_sel_o(b_wsel), .wbm_we_o(b_wwe), .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb),
        .wbm_cti_o(b_cti), .wbm_bte_o(b_bte), .wbm_ack_i(b_wack), .wbm_err_i(b_werr),
        .wbm_rty_i(b_wrty), .wbm_dat_i(b_wdati));

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (a_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b exp 0", a_cyc); end
        n_tests++; if (a_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b exp 0", a_stb); end
        n_tests++; if (a_wwe !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", a_wwe); end
        n_tests++; if (a_cti !== 3'b000) begin n_fail++; $display("FAIL reset_cti: got %b exp 000", a_cti); end
        n_tests++; if (a_wadr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h exp 0", a_wadr); end
        n_tests++; if (a_wsel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h exp 0", a_wsel); end
        n_tests++; if (a_ack !== 1'b0 || a_err !== 1'b0) begin n_fail++; $display("FAIL reset_cpu: got ack=%b err=%b exp 0 0", a_ack, a_err); end
        n_tests++; if (b_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_b_cyc: got %b exp 0", b_cyc); end
        n_tests++; if (a_bte !== 2'b10) begin n_fail++; $display("FAIL bte_a: got %b exp 10", a_bte); end
        n_tests++; if (b_bte !== 2'b01) begin n_fail++; $display("FAIL bte_b: got %b exp 01", b_bte); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        int cyc_n, ack_n, first;
        logic done;
        cyc_n = 0; ack_n = 0; first = -1; done = 1'b0;
        a_adr = 32'h103; a_we = 1'b0; a_burst = 1'b0; a_bsel = 4'hF; a_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            a_wack  = a_cyc && (cyc_n == 2);
            a_wdati = 32'hCAFE0100;
            if (a_cyc) begin
                if (first < 0) first = k;
                cyc_n++;
                n_tests++; if (a_wadr !== 32'h100 || a_cti !== 3'b000 || a_stb !== 1'b1) begin
                    n_fail++; $display("FAIL single_bus: got adr=%h cti=%b stb=%b exp 100 000 1", a_wadr, a_cti, a_stb); end
            end
            #1;
            if (a_ack) begin
                ack_n++; done = 1'b1;
                n_tests++; if (a_cdat !== 32'hCAFE0100) begin n_fail++; $display("FAIL single_data: got %h exp cafe0100", a_cdat); end
            end
        end
        a_wack = 1'b0;
        n_tests++; if (first !== 0) begin n_fail++; $display("FAIL single_latency: got %0d exp 0", first); end
        n_tests++; if (cyc_n !== 3) begin n_fail++; $display("FAIL single_cyc_len: got %0d exp 3", cyc_n); end
        n_tests++; if (ack_n !== 1) begin n_fail++; $display("FAIL single_acks: got %0d exp 1", ack_n); end
    endtask

    task automatic test_burst32;
        logic [31:0] exp_a [8] = '{32'h1018, 32'h101C, 32'h1000, 32'h1004,
                                   32'h1008, 32'h100C, 32'h1010, 32'h1014};
        logic [2:0]  exp_cti;
        int beat, fwd;
        logic done;
        beat = 0; fwd = 0; done = 1'b0;
        a_adr = 32'h1018; a_we = 1'b0; a_burst = 1'b1; a_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            a_wack = 1'b0;
            if (a_cyc) begin
                if (beat < 8) begin
                    exp_cti = (beat == 7) ? 3'b111 : 3'b010;
                    n_tests++; if (a_wadr !== exp_a[beat] || a_cti !== exp_cti) begin
                        n_fail++; $display("FAIL burst32_beat%0d: got adr=%h cti=%b exp %h %b", beat, a_wadr, a_cti, exp_a[beat], exp_cti); end
                end
                a_wack  = 1'b1;
                a_wdati = 32'hA5000000 | a_wadr;
                beat++;
            end
            #1;
            if (a_ack) begin
                fwd++;
                n_tests++; if (a_cdat !== (32'hA5000000 | a_wadr)) begin
                    n_fail++; $display("FAIL burst32_data: got %h exp %h", a_cdat, 32'hA5000000 | a_wadr); end
                if (fwd == 8) done = 1'b1;
            end
        end
        a_wack = 1'b0; a_burst = 1'b0;
        n_tests++; if (beat !== 8) begin n_fail++; $display("FAIL burst32_beats: got %0d exp 8", beat); end
        n_tests++; if (fwd !== 8) begin n_fail++; $display("FAIL burst32_acks: got %0d exp 8", fwd); end
    endtask

    task automatic test_burst64;
        logic [31:0] exp_a [4] = '{32'h2010, 32'h2018, 32'h2000, 32'h2008};
        logic [2:0]  exp_cti;
        int beat, fwd;
        logic done;
        beat = 0; fwd = 0; done = 1'b0;
        b_adr = 32'h2014; b_we = 1'b0; b_burst = 1'b1; b_bsel = 8'hFF;
        b_dat = 64'h0123456789ABCDEF; b_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) b_req = 1'b0;
            b_wack = 1'b0;
            if (b_cyc) begin
                if (beat < 4) begin
                    exp_cti = (beat == 3) ? 3'b111 : 3'b010;
                    n_tests++; if (b_wadr !== exp_a[beat] || b_cti !== exp_cti || b_wsel !== 8'hFF || b_stb !== 1'b1 || b_wwe !== 1'b0) begin
                        n_fail++; $display("FAIL burst64_beat%0d: got adr=%h cti=%b sel=%h stb=%b we=%b exp %h %b ff 1 0",
                                           beat, b_wadr, b_cti, b_wsel, b_stb, b_wwe, exp_a[beat], exp_cti); end
                end
                b_wack  = 1'b1;
                b_wdati = {32'h5A5A5A5A, b_wadr};
                beat++;
            end
            #1;
            if (b_err) begin n_tests++; n_fail++; $display("FAIL burst64_err: got 1 exp 0"); end
            if (b_ack) begin
                fwd++;
                n_tests++; if (b_cdat !== {32'h5A5A5A5A, b_wadr}) begin
                    n_fail++; $display("FAIL burst64_data: got %h exp %h", b_cdat, {32'h5A5A5A5A, b_wadr}); end
                if (fwd == 4) done = 1'b1;
            end
        end
        b_wack = 1'b0; b_burst = 1'b0;
        n_tests++; if (fwd !== 4 || beat !== 4) begin n_fail++; $display("FAIL burst64_count: got acks=%0d beats=%0d exp 4 4", fwd, beat); end
        n_tests++; if (b_wdat !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL burst64_wdat: got %h exp 0123456789abcdef", b_wdat); end
    endtask

    task automatic test_retry_write;
        int n_cyc, low, ngap, ack_n, err_n;
        int gaps [4];
        logic prev, done;
        n_cyc = 0; low = 0; ngap = 0; ack_n = 0; err_n = 0; prev = 1'b0; done = 1'b0;
        gaps = '{-1, -1, -1, -1};
        a_adr = 32'h40; a_we = 1'b1; a_dat = 32'h12345678; a_bsel = 4'h3; a_burst = 1'b0; a_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            a_wack = 1'b0; a_wrty = 1'b0;
            if (a_cyc) begin
                if (!prev && n_cyc > 0) begin
                    if (ngap < 4) gaps[ngap] = low;
                    ngap++;
                end
                low = 0;
                n_tests++; if (a_wadr !== 32'h40 || a_wwe !== 1'b1 || a_wdat !== 32'h12345678 || a_wsel !== 4'h3) begin
                    n_fail++; $display("FAIL retry_bus: got adr=%h we=%b dat=%h sel=%h exp 40 1 12345678 3", a_wadr, a_wwe, a_wdat, a_wsel); end
                if (n_cyc < 2) a_wrty = 1'b1;
                else           a_wack = 1'b1;
                n_cyc++;
            end else begin
                low++;
            end
            prev = a_cyc;
            #1;
            if (a_ack) begin ack_n++; done = 1'b1; end
            if (a_err) err_n++;
        end
        a_wack = 1'b0; a_wrty = 1'b0; a_we = 1'b0;
        n_tests++; if (n_cyc !== 3) begin n_fail++; $display("FAIL retry_issues: got %0d exp 3", n_cyc); end
        n_tests++; if (ngap !== 2 || gaps[0] !== 4 || gaps[1] !== 4) begin
            n_fail++; $display("FAIL retry_backoff: got n=%0d gaps=%0d,%0d exp 2 4,4", ngap, gaps[0], gaps[1]); end
        n_tests++; if (ack_n !== 1 || err_n !== 0) begin n_fail++; $display("FAIL retry_result: got ack=%0d err=%0d exp 1 0", ack_n, err_n); end
    endtask

    task automatic test_retry_exhaust;
        int n_cyc, ack_n, err_n;
        logic done;
        n_cyc = 0; ack_n = 0; err_n = 0; done = 1'b0;
        a_adr = 32'h80; a_we = 1'b0; a_burst = 1'b0; a_req = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            a_wrty  = a_cyc;
            a_wdati = 32'h77777777;
            if (a_cyc) n_cyc++;
            #1;
            if (a_ack) ack_n++;
            if (a_err) begin
                err_n++; done = 1'b1;
                n_tests++; if (a_cdat !== 32'h0) begin n_fail++; $display("FAIL exhaust_err_data: got %h exp 0", a_cdat); end
            end
        end
        a_wrty = 1'b0;
        n_tests++; if (n_cyc !== 4) begin n_fail++; $display("FAIL exhaust_issues: got %0d exp 4", n_cyc); end
        n_tests++; if (err_n !== 1 || ack_n !== 0) begin n_fail++; $display("FAIL exhaust_result: got err=%0d ack=%0d exp 1 0", err_n, ack_n); end
    endtask

    task automatic test_err_ack;
        int ack_n, err_n;
        logic done;
        ack_n = 0; err_n = 0; done = 1'b0;
        a_adr = 32'h200; a_we = 1'b0; a_burst = 1'b0; a_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            a_wack = a_cyc; a_werr = a_cyc; a_wdati = 32'hDEADBEEF;
            #1;
            if (a_ack) ack_n++;
            if (a_err) begin
                err_n++; done = 1'b1;
                n_tests++; if (a_cdat !== 32'h0) begin n_fail++; $display("FAIL errack_data: got %h exp 0", a_cdat); end
            end
        end
        a_wack = 1'b0; a_werr = 1'b0;
        n_tests++; if (err_n !== 1 || ack_n !== 0) begin n_fail++; $display("FAIL errack_result: got err=%0d ack=%0d exp 1 0", err_n, ack_n); end
    endtask

    task automatic test_abort;
        int n_cyc, bus_ack, fwd;
        logic drop;
        n_cyc = 0; bus_ack = 0; fwd = 0; drop = 1'b0;
        a_adr = 32'h1000; a_we = 1'b0; a_burst = 1'b1; a_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (drop) a_req = 1'b0;
            a_wack = a_cyc && (n_cyc % 2 == 1);
            a_wdati = 32'h0000AB00;
            if (a_wack) bus_ack++;
            if (a_cyc) n_cyc++;
            #1;
            if (a_ack) begin fwd++; if (fwd == 2) drop = 1'b1; end
        end
        a_wack = 1'b0; a_burst = 1'b0;
        n_tests++; if (fwd !== 2) begin n_fail++; $display("FAIL abort_fwd: got %0d exp 2", fwd); end
        n_tests++; if (bus_ack !== 3 || n_cyc !== 6) begin n_fail++; $display("FAIL abort_bus: got acks=%0d cyc=%0d exp 3 6", bus_ack, n_cyc); end
    endtask

    task automatic test_no_cyc_resp;
        a_req = 1'b0;
        @(negedge clk);
        a_wack = 1'b1; a_werr = 1'b1; a_wrty = 1'b1; a_wdati = 32'h11111111;
        #1;
        n_tests++; if (a_ack !== 1'b0 || a_err !== 1'b0 || a_cdat !== 32'h0) begin
            n_fail++; $display("FAIL idle_resp: got ack=%b err=%b dat=%h exp 0 0 0", a_ack, a_err, a_cdat); end
        @(negedge clk);
        a_wack = 1'b0; a_werr = 1'b0; a_wrty = 1'b0;
        n_tests++; if (a_cyc !== 1'b0) begin n_fail++; $display("FAIL idle_resp_cyc: got %b exp 0", a_cyc); end
    endtask

    task automatic test_timeout;
        int rise_k, err_k, err_n;
        logic done;
        rise_k = -1; err_k = -1; err_n = 0; done = 1'b0;
        a_adr = 32'h300; a_we = 1'b0; a_burst = 1'b0; a_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) a_req = 1'b0;
            if (a_cyc && rise_k < 0) rise_k = k;
            #1;
            if (a_err) begin err_n++; err_k = k; done = 1'b1; end
        end
`ifdef MOR1KX_BUS_IF_WB_TIMEOUT_EN
        n_tests++; if (err_n !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d exp 1", err_n); end
        n_tests++; if (err_k - rise_k !== 16) begin n_fail++; $display("FAIL timeout_delay: got %0d exp 16", err_k - rise_k); end
`else
        n_tests++; if (err_n !== 0) begin n_fail++; $display("FAIL no_timeout_err: got %0d exp 0 (err at %0d)", err_n, err_k); end
        n_tests++; if (a_cyc !== 1'b1) begin n_fail++; $display("FAIL no_timeout_wait: got cyc=%b exp 1", a_cyc); end
        @(negedge clk);
        a_wack = 1'b1;
        #1;
        n_tests++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL late_ack: got %b exp 1", a_ack); end
        @(negedge clk);
        a_wack = 1'b0; a_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        a_adr = 32'h400; a_we = 1'b0; a_burst = 1'b0; a_req = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (a_cyc !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got cyc=%b exp 1", a_cyc); end
        rst = 1'b1; a_req = 1'b0;
        @(negedge clk);
        n_tests++; if (a_cyc !== 1'b0 || a_wadr !== 32'h0 || a_cti !== 3'b000) begin
            n_fail++; $display("FAIL midrst_clear: got cyc=%b adr=%h cti=%b exp 0 0 000", a_cyc, a_wadr, a_cti); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (a_cyc !== 1'b0) begin n_fail++; $display("FAIL midrst_post: got cyc=%b exp 0", a_cyc); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_burst = 1'b0; a_adr = '0; a_dat = '0; a_bsel = '0;
        a_wack = 1'b0; a_werr = 1'b0; a_wrty = 1'b0; a_wdati = '0;
        b_req = 1'b0; b_we = 1'b0; b_burst = 1'b0; b_adr = '0; b_dat = '0; b_bsel = '0;
        b_wack = 1'b0; b_werr = 1'b0; b_wrty = 1'b0; b_wdati = '0;
        test_reset;
        test_single_read;
        test_burst32;
        test_burst64;
        test_retry_write;
        test_retry_exhaust;
        test_err_ack;
        test_abort;
        test_no_cyc_resp;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
